// File: rtl/seq_mult_8bit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_mult_8bit_pkg
// Brief    : Shared state encoding and iteration constants for seq_mult_8bit.
// Revision : 1.0
// ============================================================================
package seq_mult_8bit_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int ITER  = 8;
    localparam int CNT_W = 4;

endpackage : seq_mult_8bit_pkg
`default_nettype wire

// File: rtl/seq_mult_8bit_rca.sv
`default_nettype none
// ============================================================================
// Module   : rca_8bit
// Brief    : 8-bit ripple-carry adder used for each partial-sum add.
// Revision : 1.0
// ============================================================================
module rca_8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       c_in,
    output logic [7:0] sum,
    output logic       c_out
);

    logic [8:0] w_c;

    assign w_c[0] = c_in;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_bit
            assign sum[gi]    = a[gi] ^ b[gi] ^ w_c[gi];
            assign w_c[gi+1]  = (a[gi] & b[gi]) | (w_c[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign c_out = w_c[8];

endmodule : rca_8bit
`default_nettype wire

// File: rtl/seq_mult_8bit.sv
`default_nettype none
// ============================================================================
// Module   : seq_mult_8bit
// Brief    : Sequential 8x8 unsigned shift-and-add multiplier, start/done handshake.
// Revision : 1.0
// ============================================================================
module seq_mult_8bit
    import seq_mult_8bit_pkg::*;
#(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] p
);

    localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(ITER - 1);

    generate
        if (W != 8) begin : g_bad_width
            $error("seq_mult_8bit: W must be 8 (bound to rca_8bit)");
        end
    endgenerate

    state_t           r_state;
    state_t           w_state_nxt;
    logic [W-1:0]     r_m;
    logic [W-1:0]     r_acc;
    logic [W-1:0]     r_q;
    logic [CNT_W-1:0] r_cnt;
    logic [2*W-1:0]   r_p;

    logic             w_load;
    logic             w_finish;
    logic [W-1:0]     w_sum;
    logic             w_cout;
    logic [W-1:0]     w_acc_nxt;
    logic [W-1:0]     w_q_nxt;

    rca_8bit u_rca (
        .a     (r_acc),
        .b     (r_m),
        .c_in  (1'b0),
        .sum   (w_sum),
        .c_out (w_cout)
    );

    // The adder carry-out becomes the new acc MSB, so the 17-bit {c,sum,q} shifts right as one.
    always_comb begin
        if (r_q[0]) begin
            w_acc_nxt = {w_cout, w_sum[W-1:1]};
            w_q_nxt   = {w_sum[0], r_q[W-1:1]};
        end else begin
            w_acc_nxt = {1'b0, r_acc[W-1:1]};
            w_q_nxt   = {r_acc[0], r_q[W-1:1]};
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (r_cnt == c_last_cnt) begin
                    w_finish    = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m   <= '0;
            r_acc <= '0;
            r_q   <= '0;
            r_cnt <= '0;
            r_p   <= '0;
        end else if (w_load) begin
            r_m   <= a;
            r_q   <= b;
            r_acc <= '0;
            r_cnt <= '0;
        end else if (r_state == S_RUN) begin
            r_acc <= w_acc_nxt;
            r_q   <= w_q_nxt;
            r_cnt <= r_cnt + 1'b1;
            if (w_finish) begin
                r_p <= {w_acc_nxt, w_q_nxt};
            end
        end
    end

    assign busy = (r_state == S_RUN);
    assign done = (r_state == S_DONE);
    assign p    = r_p;

endmodule : seq_mult_8bit
`default_nettype wire

// File: tb/tb_seq_mult_8bit.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_mult_8bit
// Brief    : Self-checking bench: directed vector table, handshake corner cases, random a*b.
// Revision : 1.0
// ============================================================================
module tb_seq_mult_8bit;

    localparam int EXP_LAT  = 9;
    localparam int EXP_BUSY = 8;
    localparam int MAX_WAIT = 20;

    typedef struct packed {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        busy;
    logic        done;
    logic [15:0] p;

    int n_cmp;
    int n_err;

    seq_mult_8bit #(.W(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .p     (p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one product from IDLE; returns once done is seen (or the wait bound expires).
    task automatic run_mult(input logic [7:0] ia, input logic [7:0] ib,
                            output logic [15:0] op, output int lat, output int busyc);
        a     = ia;
        b     = ib;
        start = 1'b1;
        tick();
        start = 1'b0;
        a     = 8'($urandom);
        b     = 8'($urandom);
        lat   = 1;
        busyc = 0;
        while (!done && lat < MAX_WAIT) begin
            if (busy) busyc++;
            tick();
            lat++;
        end
        op = p;
    endtask

    vec_t        vecs[6];
    logic [15:0] got_p;
    logic [15:0] held_p;
    int          lat;
    int          busyc;
    int          done_seen;

    initial begin
        vecs[0] = '{a: 8'd13,  b: 8'd11,  p: 16'h008F};
        vecs[1] = '{a: 8'd255, b: 8'd255, p: 16'hFE01};
        vecs[2] = '{a: 8'd0,   b: 8'd200, p: 16'h0000};
        vecs[3] = '{a: 8'd200, b: 8'd0,   p: 16'h0000};
        vecs[4] = '{a: 8'd1,   b: 8'd255, p: 16'h00FF};
        vecs[5] = '{a: 8'd7,   b: 8'd6,   p: 16'h002A};

        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        start = 1'b0;
        a     = 8'd0;
        b     = 8'd0;

        tick();
        tick();
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_p",    32'(p),    32'd0);
        rst = 1'b0;
        tick();
        tick();
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_done", 32'(done), 32'd0);
        check("idle_p",    32'(p),    32'd0);

        // Directed table
        for (int i = 0; i < 6; i++) begin
            run_mult(vecs[i].a, vecs[i].b, got_p, lat, busyc);
            check($sformatf("vec%0d_p", i),    32'(got_p), 32'(vecs[i].p));
            check($sformatf("vec%0d_lat", i),  32'(lat),   32'(EXP_LAT));
            check($sformatf("vec%0d_busy", i), 32'(busyc), 32'(EXP_BUSY));
            check($sformatf("vec%0d_nobusy_in_done", i), 32'(busy), 32'd0);
            tick();
            check($sformatf("vec%0d_done_1cyc", i), 32'(done), 32'd0);
            check($sformatf("vec%0d_p_hold", i),    32'(p),    32'(vecs[i].p));
        end

        // Start held high, operands churning during RUN, back-to-back launch from DONE
        a     = 8'd13;
        b     = 8'd11;
        start = 1'b1;
        tick();
        lat = 1;
        while (!done && lat < MAX_WAIT) begin
            a = 8'($urandom);
            b = 8'($urandom);
            check("held_p_stable", 32'(p), 32'h002A);
            tick();
            lat++;
        end
        check("held_first_p",   32'(p),   32'h008F);
        check("held_first_lat", 32'(lat), 32'(EXP_LAT));
        a = 8'd3;
        b = 8'd5;
        tick();
        check("b2b_busy", 32'(busy), 32'd1);
        start = 1'b0;
        lat = 1;
        while (!done && lat < MAX_WAIT) begin
            tick();
            lat++;
        end
        check("b2b_p",       32'(p),   32'h000F);
        check("b2b_spacing", 32'(lat), 32'(EXP_LAT));
        tick();
        check("b2b_idle", 32'(busy | done), 32'd0);

        // Asynchronous reset in RUN cycle 4
        a     = 8'd200;
        b     = 8'd200;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        check("abort_busy_before", 32'(busy), 32'd1);
        check("abort_p_before",    32'(p),    32'h000F);
        rst = 1'b1;
        #1;
        check("abort_p",    32'(p),    32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        #2;
        rst = 1'b0;
        done_seen = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (done) done_seen++;
        end
        check("abort_no_done", 32'(done_seen), 32'd0);
        run_mult(8'd7, 8'd6, got_p, lat, busyc);
        check("after_abort_p",   32'(got_p), 32'd42);
        check("after_abort_lat", 32'(lat),   32'(EXP_LAT));
        tick();

        // Random pairs against plain arithmetic
        for (int i = 0; i < 1000; i++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            logic [15:0] exp_p;
            ra    = 8'($urandom);
            rb    = 8'($urandom);
            exp_p = 16'(ra) * 16'(rb);
            run_mult(ra, rb, got_p, lat, busyc);
            check($sformatf("rand%0d_p(%0d*%0d)", i, ra, rb), 32'(got_p), 32'(exp_p));
            check($sformatf("rand%0d_lat", i), 32'(lat), 32'(EXP_LAT));
            held_p = got_p;
            tick();
            check($sformatf("rand%0d_hold", i), 32'(p), 32'(held_p));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_seq_mult_8bit
`default_nettype wire
